// File: rtl/filter_sink_fifo_if.sv
// Stream and status bundle for filter_sink_fifo: filter-side beats in, buffered beats out.
// slave is the FIFO's view of the bundle; master is the view of whatever drives and consumes it.
interface filter_sink_fifo_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] io_x_data;
  logic             io_x_valid;
  logic             io_x_parity;
  logic [WIDTH-1:0] io_y_data;
  logic             io_y_parity;
  logic             io_y_valid;
  logic             io_y_ready;
  logic [CW-1:0]    io_count;
  logic             io_overflow;
  logic [CNTW-1:0]  io_parity_cnt;
  logic             io_clear;

  modport slave (
    input  io_x_data, io_x_valid, io_x_parity, io_y_ready, io_clear,
    output io_y_data, io_y_parity, io_y_valid, io_count, io_overflow, io_parity_cnt
  );

  modport master (
    output io_x_data, io_x_valid, io_x_parity, io_y_ready, io_clear,
    input  io_y_data, io_y_parity, io_y_valid, io_count, io_overflow, io_parity_cnt
  );
endinterface

// File: rtl/filter_sink_fifo.sv
// Small FIFO sink for the filter output stream. The upstream chain cannot stall, so beats that
// arrive when the FIFO is full and nothing pops are dropped and flagged in a sticky overflow bit.
module filter_sink_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 8
) (
  input logic clk,
  input logic reset,
  filter_sink_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [AW-1:0]   r_rdPtr;
  logic [AW-1:0]   r_wrPtr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic [CNTW-1:0] r_parityCnt;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_parityPush;

  // A full FIFO still accepts a beat when its head is popped in the same cycle.
  assign w_full       = (r_count == FULL_COUNT);
  assign w_pop        = (r_count != '0) & bus.io_y_ready;
  assign w_push       = bus.io_x_valid & (~w_full | w_pop);
  assign w_drop       = bus.io_x_valid & w_full & ~w_pop;
  assign w_parityPush = w_push & bus.io_x_parity;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {bus.io_x_parity, bus.io_x_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // A drop in the same cycle as a clear keeps the overflow flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_parityCnt <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.io_clear) begin
        r_overflow <= 1'b0;
      end
      if (bus.io_clear) begin
        r_parityCnt <= w_parityPush ? CNTW'(1) : '0;
      end else if (w_parityPush) begin
        r_parityCnt <= r_parityCnt + CNTW'(1);
      end
    end
  end

  assign bus.io_y_data     = r_mem[r_rdPtr][WIDTH-1:0];
  assign bus.io_y_parity   = r_mem[r_rdPtr][WIDTH];
  assign bus.io_y_valid    = (r_count != '0);
  assign bus.io_count      = r_count;
  assign bus.io_overflow   = r_overflow;
  assign bus.io_parity_cnt = r_parityCnt;
endmodule

// File: tb/tb_filter_sink_fifo.sv
// Directed bench for filter_sink_fifo (DEPTH=4, WIDTH=16, CNTW=8) with hand-computed expectations.
module tb_filter_sink_fifo;
  logic clk;
  logic reset;
  int   nAsserts;
  int   nFails;

  filter_sink_fifo_if #(.DEPTH(4), .WIDTH(16), .CNTW(8)) bus ();

  filter_sink_fifo #(.DEPTH(4), .WIDTH(16), .CNTW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic parity,
                               input logic ready, input logic clear);
    bus.io_x_valid  = valid;
    bus.io_x_data   = data;
    bus.io_x_parity = parity;
    bus.io_y_ready  = ready;
    bus.io_clear    = clear;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      $error("[TB] assertion %s violated", tag);
    end
  endtask

  initial begin
    nAsserts = 0;
    nFails   = 0;
    reset    = 1'b1;
    bus.io_x_valid  = 1'b0;
    bus.io_x_data   = '0;
    bus.io_x_parity = 1'b0;
    bus.io_y_ready  = 1'b0;
    bus.io_clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 16'h0, 0, 0, 0);
    checkOutput("rst_valid", bus.io_y_valid, 0);
    checkOutput("rst_count", bus.io_count, 0);
    checkOutput("rst_ovf", bus.io_overflow, 0);
    checkOutput("rst_pcnt", bus.io_parity_cnt, 0);

    // Single beat with one-cycle latency, then popped.
    applyStimulus(1, 16'h1234, 1, 0, 0);
    bus.io_x_valid = 1'b0;
    checkOutput("single_valid", bus.io_y_valid, 1);
    checkOutput("single_data", bus.io_y_data, 32'h1234);
    checkOutput("single_par", bus.io_y_parity, 1);
    checkOutput("single_count", bus.io_count, 1);
    checkOutput("single_pcnt", bus.io_parity_cnt, 1);
    applyStimulus(0, 16'h0, 0, 1, 0);
    checkOutput("pop_valid", bus.io_y_valid, 0);
    checkOutput("pop_count", bus.io_count, 0);

    // Reset between edges clears state immediately.
    applyStimulus(1, 16'h5555, 0, 0, 0);
    bus.io_x_valid = 1'b0;
    checkOutput("pre_rst_count", bus.io_count, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", bus.io_y_valid, 0);
    checkOutput("midrst_count", bus.io_count, 0);
    checkOutput("midrst_pcnt", bus.io_parity_cnt, 0);
    checkOutput("midrst_ovf", bus.io_overflow, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill past DEPTH with no consumer: fifth beat is dropped.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 16'(i), 0, 0, 0);
    end
    bus.io_x_valid = 1'b0;
    checkOutput("fill_count", bus.io_count, 4);
    checkOutput("fill_ovf", bus.io_overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("fill_drain%0d", i), bus.io_y_data, i);
      applyStimulus(0, 16'h0, 0, 1, 0);
    end
    checkOutput("fill_empty", bus.io_y_valid, 0);
    checkOutput("fill_ovf_sticky", bus.io_overflow, 1);

    // Full with simultaneous push and pop: nothing lost, pointers wrap.
    applyStimulus(0, 16'h0, 0, 0, 1);
    checkOutput("clr1_ovf", bus.io_overflow, 0);
    applyStimulus(1, 16'h000A, 0, 0, 0);
    applyStimulus(1, 16'h000B, 0, 0, 0);
    applyStimulus(1, 16'h000C, 0, 0, 0);
    applyStimulus(1, 16'h000D, 0, 0, 0);
    applyStimulus(1, 16'h000E, 0, 1, 0);
    bus.io_x_valid = 1'b0;
    checkOutput("pp_count", bus.io_count, 4);
    checkOutput("pp_ovf", bus.io_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("pp_drain%0d", i), bus.io_y_data, 32'hB + i);
      applyStimulus(0, 16'h0, 0, 1, 0);
    end
    checkOutput("pp_empty", bus.io_count, 0);

    // Streaming with ready always high; parity on every third beat (7 of 20).
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 16'h0100 + 16'(i), (i % 3) == 0, 1, 0);
      checkOutput($sformatf("stream_data%0d", i), bus.io_y_data, 32'h100 + i);
      checkOutput($sformatf("stream_count%0d", i), bus.io_count, 1);
    end
    applyStimulus(0, 16'h0, 0, 1, 0);
    checkOutput("stream_empty", bus.io_count, 0);
    checkOutput("stream_ovf", bus.io_overflow, 0);
    checkOutput("stream_pcnt", bus.io_parity_cnt, 7);

    // Build overflow=1 with parity count still 7, then clear alone.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 16'h0020 + 16'(i), 0, 0, 0);
    end
    checkOutput("pre_clr_ovf", bus.io_overflow, 1);
    checkOutput("pre_clr_pcnt", bus.io_parity_cnt, 7);
    applyStimulus(0, 16'h0, 0, 0, 1);
    checkOutput("clr_ovf", bus.io_overflow, 0);
    checkOutput("clr_pcnt", bus.io_parity_cnt, 0);
    checkOutput("clr_count", bus.io_count, 4);
    checkOutput("clr_head", bus.io_y_data, 32'h21);

    // Clear with a drop: set wins, dropped parity beat not counted.
    applyStimulus(1, 16'h00FF, 1, 0, 1);
    checkOutput("clrdrop_ovf", bus.io_overflow, 1);
    checkOutput("clrdrop_pcnt", bus.io_parity_cnt, 0);
    checkOutput("clrdrop_count", bus.io_count, 4);
    applyStimulus(1, 16'h0031, 1, 1, 0);
    applyStimulus(1, 16'h0032, 0, 1, 0);
    checkOutput("pp_pcnt", bus.io_parity_cnt, 1);
    applyStimulus(1, 16'h0033, 1, 1, 0);
    checkOutput("pp_pcnt2", bus.io_parity_cnt, 2);
    // Clear with a parity push: counter restarts at 1.
    applyStimulus(1, 16'h0034, 1, 1, 1);
    bus.io_x_valid = 1'b0;
    checkOutput("clrpush_pcnt", bus.io_parity_cnt, 1);
    checkOutput("clrpush_ovf", bus.io_overflow, 0);
    checkOutput("clrpush_count", bus.io_count, 4);
    checkOutput("clrpush_head", bus.io_y_data, 32'h31);
    checkOutput("clrpush_hpar", bus.io_y_parity, 1);
    applyStimulus(0, 16'h0, 0, 1, 0);
    checkOutput("drain_32", bus.io_y_data, 32'h32);
    checkOutput("drain_32par", bus.io_y_parity, 0);
    applyStimulus(0, 16'h0, 0, 1, 0);
    applyStimulus(0, 16'h0, 0, 1, 0);
    checkOutput("drain_34", bus.io_y_data, 32'h34);
    applyStimulus(0, 16'h0, 0, 1, 0);
    checkOutput("drain_empty", bus.io_y_valid, 0);

    // Parity counter wraps: 1 + 255 = 256 -> 0.
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1, 16'(i), 1, 1, 0);
    end
    checkOutput("wrap_pcnt", bus.io_parity_cnt, 0);
    checkOutput("wrap_count", bus.io_count, 1);
    applyStimulus(0, 16'h0, 0, 1, 0);
    checkOutput("wrap_empty", bus.io_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
